load_unit: RTL

Load-side initiator for the word-organised data RAM. Accepts byte, halfword and word load requests from the core. Issues one or two synchronous RAM word reads; two are needed when the access crosses a word boundary. Merges the returned words, then extracts and sign- or zero-extends the selected bytes, and returns a single-cycle response. Sits between the core's memory stage and the RAM read port; the store path is separate.

---
 rtl/load_pkg.sv | 33 +++
 rtl/load_align.sv | 39 +++
 rtl/load_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/load_pkg.sv
// load_pkg
// Shared definitions for the load path: access-size encoding (identical to
// the RAM mem_ctrl encoding), the load FSM state type and the split test.
// No ports.
package load_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPLO,
        ST_CAPHI,
        ST_RESP
    } state_t;

    // An access needs a second word when its last byte lies past offset 3.
    // The reserved size is addressed like a word.
    function automatic logic needs_split(input logic [1:0] size, input logic [1:0] off);
        logic split;
        split = 1'b0;
        case (size)
            SZ_BYTE: split = 1'b0;
            SZ_HALF: split = (off == 2'd3);
            default: split = (off != 2'd0);
        endcase
        return split;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align
// Combinational lane extraction and extension for loads.
// Ports:
//   merged   in  64  {hi, lo} word pair, lo at bits 31:0
//   off      in  2   byte offset of the first byte within lo
//   size     in  2   access size (load_pkg SZ_* encoding)
//   zero_ext in  1   1 zero-extends bytes/halves, 0 sign-extends
//   result   out 32  aligned, extended value
module load_align
    import load_pkg::*;
(
    input  logic [63:0] merged,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] result
);

    logic [31:0] lane;
    logic        sign;

    always_comb begin
        lane   = merged[{off, 3'b000} +: 32];
        sign   = 1'b0;
        result = lane;
        case (size)
            SZ_BYTE: begin
                sign   = ~zero_ext & lane[7];
                result = {{24{sign}}, lane[7:0]};
            end
            SZ_HALF: begin
                sign   = ~zero_ext & lane[15];
                result = {{16{sign}}, lane[15:0]};
            end
            default: result = lane;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// load_unit
// Load-side initiator for the word-organised data RAM. Accepts byte, half and
// word loads, issues one or two RAM word reads (two when the access crosses a
// word boundary), merges and extends the data and returns a one-cycle response.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_addr, req_size     byte address and access size
//   req_unsigned           zero-extend when set
//   mem_rd_en, mem_addr    RAM read strobe and word address (registered)
//   mem_rdata              RAM data, valid the cycle after mem_rd_en
//   rsp_valid, rsp_data    one-cycle response pulse and held result
//   rsp_err                response used the reserved size
module load_unit
    import load_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err
);

    state_t            state, state_next;
    logic [1:0]        off_q, size_q;
    logic              zext_q, split_q;
    logic [ADDR_W-1:0] wa_q, req_wa, addr_next;
    logic [31:0]       lo_q, aligned;
    logic [63:0]       merged;
    logic              accept, rd_en_next, rsp_next;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];
    assign req_wa    = req_addr[ADDR_W+1:2];
    assign req_ready = (state == ST_IDLE) || (state == ST_RESP);
    assign accept    = req_valid && req_ready;

    load_align u_align (
        .merged   (merged),
        .off      (off_q),
        .size     (size_q),
        .zero_ext (zext_q),
        .result   (aligned)
    );

    // Next state plus the values the registered outputs take in that state.
    // The response is formed while the last RAM word is on mem_rdata.
    always_comb begin
        state_next = state;
        rd_en_next = 1'b0;
        addr_next  = mem_addr;
        rsp_next   = 1'b0;
        merged     = {32'h0, lo_q};
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ISSUE;
                    rd_en_next = 1'b1;
                    addr_next  = req_wa;
                end
            end
            ST_ISSUE: begin
                state_next = ST_CAPLO;
                if (split_q) begin
                    rd_en_next = 1'b1;
                    addr_next  = wa_q + 1'b1;
                end
            end
            ST_CAPLO: begin
                merged = {32'h0, mem_rdata};
                if (split_q) begin
                    state_next = ST_CAPHI;
                end else begin
                    state_next = ST_RESP;
                    rsp_next   = 1'b1;
                end
            end
            ST_CAPHI: begin
                merged     = {mem_rdata, lo_q};
                state_next = ST_RESP;
                rsp_next   = 1'b1;
            end
            ST_RESP: begin
                if (accept) begin
                    state_next = ST_ISSUE;
                    rd_en_next = 1'b1;
                    addr_next  = req_wa;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_next;
            mem_rd_en <= rd_en_next;
            mem_addr  <= addr_next;
            rsp_valid <= rsp_next;
        end
    end

    // Request fields are latched on accept; rsp_data holds until next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q    <= '0;
            size_q   <= '0;
            zext_q   <= 1'b0;
            split_q  <= 1'b0;
            wa_q     <= '0;
            lo_q     <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                off_q   <= req_addr[1:0];
                size_q  <= req_size;
                zext_q  <= req_unsigned;
                split_q <= needs_split(req_size, req_addr[1:0]);
                wa_q    <= req_wa;
            end
            if (state == ST_CAPLO) begin
                lo_q <= mem_rdata;
            end
            if (rsp_next) begin
                rsp_data <= aligned;
                rsp_err  <= (size_q == SZ_RSVD);
            end
        end
    end

endmodule
